// File: rtl/clock_pkg.sv
// Shared types and helpers for the hh:mm:ss timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_RSVD = 2'd3
    } field_e;

    localparam logic [6:0] MOD_SEC  = 7'd60;
    localparam logic [6:0] MOD_MIN  = 7'd60;
    localparam logic [6:0] MOD_HOUR = 7'd24;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    // One modular add/subtract; returns {carry_or_borrow, value}.
    // Callers keep amt below the modulus, so at most one carry/borrow occurs.
    function automatic logic [7:0] mod_step(input logic [6:0] v, input logic [6:0] amt,
                                            input logic up, input logic [6:0] modulus);
        logic [6:0] sum;
        logic [7:0] res;
        if (up) begin
            sum = v + amt;
            res = (sum >= modulus) ? {1'b1, sum - modulus} : {1'b0, sum};
        end else begin
            res = (v >= amt) ? {1'b0, v - amt} : {1'b1, v + modulus - amt};
        end
        return res;
    endfunction

    // Add/subtract amt to one field; carry/borrow ripples only upward, hour wraps.
    function automatic hms_t hms_add(input hms_t t, input field_e f,
                                     input logic [6:0] amt, input logic up);
        logic [7:0] s, m, h;
        logic [6:0] amt_m, amt_h;
        hms_t r;
        s     = mod_step({1'b0, t.sec}, (f == FIELD_SEC) ? amt : 7'd0, up, MOD_SEC);
        amt_m = (f == FIELD_MIN) ? amt : {6'd0, s[7]};
        m     = mod_step({1'b0, t.min}, amt_m, up, MOD_MIN);
        amt_h = (f == FIELD_HOUR) ? amt : {6'd0, m[7]};
        h     = mod_step({2'b0, t.hour}, amt_h, up, MOD_HOUR);
        r.sec  = 6'(s[6:0]);
        r.min  = 6'(m[6:0]);
        r.hour = 5'(h[6:0]);
        return r;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Control, adjust, alarm and time-output bundle of the timekeeper.
interface rtc_timekeeper_if #(parameter int unsigned N_LED = 10);
    logic             run;
    logic             mode12;
    logic             adj_valid;
    logic [1:0]       adj_field;
    logic             adj_dir;
    logic [5:0]       adj_amt;
    logic             alarm_en;
    logic [4:0]       alarm_h;
    logic [5:0]       alarm_m;
    logic             alarm_ack;
    logic [4:0]       hour;
    logic [5:0]       min;
    logic [5:0]       sec;
    logic [4:0]       hour_disp;
    logic             pm;
    logic             tick;
    logic             adj_err;
    logic             ringing;
    logic [N_LED-1:0] led;

    modport master (
        output run, mode12, adj_valid, adj_field, adj_dir, adj_amt,
               alarm_en, alarm_h, alarm_m, alarm_ack,
        input  hour, min, sec, hour_disp, pm, tick, adj_err, ringing, led
    );

    modport slave (
        input  run, mode12, adj_valid, adj_field, adj_dir, adj_amt,
               alarm_en, alarm_h, alarm_m, alarm_ack,
        output hour, min, sec, hour_disp, pm, tick, adj_err, ringing, led
    );
endinterface

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-second tick request.
module rtc_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick_req
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, parked at zero while time is frozen.
    always_ff @(posedge clk) begin
        if (reset || !run)  cnt <= '0;
        else if (cnt == TERM) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end

    assign tick_req = run && (cnt == TERM);
endmodule

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss timekeeper: tick/adjust arbitration, 12/24 h display, alarm, progress bar.
module rtc_timekeeper
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned INIT_H    = 0,
    parameter int unsigned INIT_M    = 0,
    parameter int unsigned INIT_S    = 0,
    parameter int unsigned N_LED     = 10,
    parameter int unsigned RING_SECS = 60
) (
    input logic             clk,
    input logic             reset,
    rtc_timekeeper_if.slave bus
);
    localparam hms_t T_INIT = '{hour: 5'(INIT_H), min: 6'(INIT_M), sec: 6'(INIT_S)};
    localparam int unsigned RCW = $clog2(RING_SECS + 1);
    localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECS - 1);

    hms_t           t, t_tick, t_adj;
    logic           tick_req, tick_pending, tick_go, adj_ok, match;
    logic           tick_q, adj_err_q, ringing_q;
    logic [RCW-1:0] ring_cnt;
    logic [6:0]     amt;
    logic [4:0]     hour_disp;
    logic [11:0]    sec_scaled;
    logic [N_LED-1:0] led;

    rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .run      (bus.run),
        .tick_req (tick_req)
    );

    assign amt     = {1'b0, bus.adj_amt};
    // An adjust owns the cycle; a tick (new or deferred) goes through otherwise.
    assign tick_go = !bus.adj_valid && (tick_req || tick_pending);
    assign t_tick  = hms_add(t, FIELD_SEC, 7'd1, 1'b1);
    assign t_adj   = hms_add(t, field_e'(bus.adj_field), amt, bus.adj_dir);
    assign match   = (t_tick.sec == 6'd0) && (t_tick.min == bus.alarm_m) &&
                     (t_tick.hour == bus.alarm_h);

    // Adjust is legal only for a real field and a magnitude below its modulus.
    always_comb begin
        adj_ok = 1'b0;
        case (field_e'(bus.adj_field))
            FIELD_SEC:  adj_ok = amt < MOD_SEC;
            FIELD_MIN:  adj_ok = amt < MOD_MIN;
            FIELD_HOUR: adj_ok = amt < MOD_HOUR;
            default:    adj_ok = 1'b0;
        endcase
    end

    // Time registers; a tick colliding with an adjust is parked for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            t            <= T_INIT;
            tick_pending <= 1'b0;
            tick_q       <= 1'b0;
            adj_err_q    <= 1'b0;
        end else begin
            tick_q    <= tick_go;
            adj_err_q <= bus.adj_valid && !adj_ok;
            if (bus.adj_valid) begin
                if (adj_ok) t <= t_adj;
                tick_pending <= tick_pending || tick_req;
            end else if (tick_go) begin
                t            <= t_tick;
                // Pending and fresh request together: apply one, keep the other.
                tick_pending <= tick_pending && tick_req;
            end
        end
    end

    // Alarm: ack/disable first, then a tick landing on hh:mm:00, then ring timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ringing_q <= 1'b0;
            ring_cnt  <= '0;
        end else if (bus.alarm_ack || !bus.alarm_en) begin
            ringing_q <= 1'b0;
        end else if (tick_go && match) begin
            ringing_q <= 1'b1;
            ring_cnt  <= '0;
        end else if (tick_go && ringing_q) begin
            if (ring_cnt == RING_LAST) ringing_q <= 1'b0;
            else                       ring_cnt  <= ring_cnt + 1'b1;
        end
    end

    // 12 h view maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        hour_disp = t.hour;
        if (bus.mode12) begin
            if (t.hour == 5'd0)       hour_disp = 5'd12;
            else if (t.hour > 5'd12)  hour_disp = t.hour - 5'd12;
        end
    end

    assign sec_scaled = 12'(t.sec) * 12'(N_LED);
    for (genvar i = 0; i < N_LED; i++) begin : g_led
        assign led[i] = sec_scaled > 12'(i * 60);
    end

    assign bus.hour      = t.hour;
    assign bus.min       = t.min;
    assign bus.sec       = t.sec;
    assign bus.hour_disp = hour_disp;
    assign bus.pm        = t.hour >= 5'd12;
    assign bus.tick      = tick_q;
    assign bus.adj_err   = adj_err_q;
    assign bus.ringing   = ringing_q;
    assign bus.led       = led;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench: seconds-of-day reference model feeds a per-cycle expectation queue.
module tb_rtc_timekeeper;
    localparam int TD = 4, IH = 23, IM = 59, IS = 58, NL = 10, RS = 5;
    localparam int DAY = 86400;

    bit   clk;
    logic reset;
    always #5 clk = ~clk;

    rtc_timekeeper_if #(.N_LED(NL)) bus();

    rtc_timekeeper #(
        .TICK_DIV(TD), .INIT_H(IH), .INIT_M(IM), .INIT_S(IS),
        .N_LED(NL), .RING_SECS(RS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int hour; int min; int sec;
        bit tick; bit err; bit ring;
    } exp_t;

    exp_t q[$];
    int   n_cmp, n_bad;

    // reference model state: time as seconds of the day
    int m_t, m_presc, m_rcnt;
    bit m_pend, m_ring;

    function automatic void chk(string nm, int act, int ex);
        n_cmp++;
        if (act != ex) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: actual %0d required %0d at %0t", nm, act, ex, $time);
        end
    endfunction

    // Advance the model by one clock using the inputs now on the bus, queue the result.
    task automatic step();
        exp_t e;
        bit req, ticked;
        int unit, modv, amt;
        e.tick = 0; e.err = 0; ticked = 0;
        if (reset) begin
            m_t = IH*3600 + IM*60 + IS; m_presc = 0; m_pend = 0; m_ring = 0; m_rcnt = 0;
        end else begin
            req = bus.run && (m_presc == TD-1);
            m_presc = !bus.run ? 0 : (m_presc == TD-1) ? 0 : m_presc + 1;
            if (bus.adj_valid) begin
                amt  = int'(bus.adj_amt);
                unit = (bus.adj_field == 2'd0) ? 1 : (bus.adj_field == 2'd1) ? 60 : 3600;
                modv = (bus.adj_field == 2'd2) ? 24 : 60;
                if (bus.adj_field == 2'd3 || amt >= modv) e.err = 1;
                else if (bus.adj_dir) m_t = (m_t + amt*unit) % DAY;
                else                  m_t = (m_t - amt*unit + DAY) % DAY;
                m_pend = m_pend || req;
            end else if (req || m_pend) begin
                m_t = (m_t + 1) % DAY;
                e.tick = 1; ticked = 1;
                m_pend = m_pend && req;
            end
            if (bus.alarm_ack || !bus.alarm_en) m_ring = 0;
            else if (ticked && m_t == int'(bus.alarm_h)*3600 + int'(bus.alarm_m)*60) begin
                m_ring = 1; m_rcnt = 0;
            end else if (ticked && m_ring) begin
                m_rcnt++;
                if (m_rcnt == RS) m_ring = 0;
            end
        end
        e.hour = m_t / 3600; e.min = (m_t / 60) % 60; e.sec = m_t % 60; e.ring = m_ring;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic adj(input int f, input int amt, input bit up);
        bus.adj_valid = 1; bus.adj_field = 2'(f); bus.adj_amt = 6'(amt); bus.adj_dir = up;
        step();
        bus.adj_valid = 0;
    endtask

    // Walk each field to its target with single adjusts (time must be frozen).
    task automatic set_time(input int h, input int m, input int s);
        int cur;
        cur = m_t % 60;        if (s >= cur) adj(0, s-cur, 1); else adj(0, cur-s, 0);
        cur = (m_t / 60) % 60; if (m >= cur) adj(1, m-cur, 1); else adj(1, cur-m, 0);
        cur = m_t / 3600;      if (h >= cur) adj(2, h-cur, 1); else adj(2, cur-h, 0);
    endtask

    // Monitor: one expectation per cycle, sampled mid-period.
    initial begin
        exp_t e;
        int dh, lit;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("hour",    int'(bus.hour),    e.hour);
                chk("min",     int'(bus.min),     e.min);
                chk("sec",     int'(bus.sec),     e.sec);
                chk("tick",    int'(bus.tick),    int'(e.tick));
                chk("adj_err", int'(bus.adj_err), int'(e.err));
                chk("ringing", int'(bus.ringing), int'(e.ring));
                dh = (bus.mode12 && e.hour == 0) ? 12 :
                     (bus.mode12 && e.hour > 12) ? e.hour - 12 : e.hour;
                chk("hour_disp", int'(bus.hour_disp), dh);
                chk("pm",        int'(bus.pm), (e.hour >= 12) ? 1 : 0);
                lit = (e.sec * NL + 59) / 60;
                chk("led",       int'(bus.led), (1 << lit) - 1);
            end
        end
    end

    initial begin
        int nt;
        reset = 1;
        bus.run = 0; bus.mode12 = 0; bus.adj_valid = 0; bus.adj_field = 0;
        bus.adj_dir = 0; bus.adj_amt = 0; bus.alarm_en = 0; bus.alarm_h = 0;
        bus.alarm_m = 0; bus.alarm_ack = 0;
        idle(2);
        // rollover 23:59:58 -> 23:59:59 -> 00:00:00
        reset = 0; bus.run = 1;
        idle(14);
        // reset in the middle of a count at 12:34:56
        bus.run = 0; idle(2); set_time(12, 34, 56);
        bus.run = 1; idle(2);
        reset = 1; step(); reset = 0;
        idle(10);
        // frozen adjusts, borrows and rejections
        bus.run = 0; idle(2);
        set_time(0, 0, 5);
        adj(0, 10, 0);
        adj(2, 24, 1);
        adj(3, 1, 1);
        adj(1, 60, 1);
        adj(0, 59, 1);
        adj(2, 23, 0);
        idle(1);
        // adjust colliding with a tick request
        set_time(10, 20, 30);
        bus.run = 1;
        while (m_presc != TD-1) step();
        adj(1, 1, 1);
        idle(3);
        // 12 h display corners
        bus.run = 0; bus.mode12 = 1; idle(2);
        set_time(0, 0, 0); set_time(13, 0, 0); set_time(12, 0, 0); idle(1);
        bus.mode12 = 0;
        // alarm rings on tick, times out
        bus.alarm_h = 7; bus.alarm_m = 0; bus.alarm_en = 1;
        set_time(6, 59, 58);
        bus.run = 1; idle(TD*12);
        // reaching 07:00:00 by adjust does not ring
        bus.run = 0; idle(2);
        set_time(7, 0, 30); adj(0, 30, 0); idle(2);
        // ack together with the match wins
        set_time(6, 59, 59);
        bus.alarm_ack = 1; bus.run = 1; idle(TD*2);
        bus.alarm_ack = 0; idle(TD*2);
        // disable clears an active ring
        bus.run = 0; idle(2); set_time(6, 59, 59);
        bus.run = 1; idle(TD*3);
        bus.alarm_en = 0; step(); bus.alarm_en = 1; idle(TD);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) bus.mode12 = ~bus.mode12;
            bus.adj_valid = ($urandom_range(0, 23) == 0);
            bus.adj_field = 2'($urandom_range(0, 3));
            bus.adj_dir   = 1'($urandom_range(0, 1));
            bus.adj_amt   = 6'($urandom_range(0, 63));
            bus.alarm_ack = ($urandom_range(0, 59) == 0);
            bus.alarm_en  = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 149) == 0) begin
                nt = (m_t + 60 - m_t % 60) % DAY;
                bus.alarm_h = 5'(nt / 3600);
                bus.alarm_m = 6'((nt / 60) % 60);
            end
            step();
        end
        reset = 0; bus.adj_valid = 0; bus.alarm_ack = 0;
        idle(3);
        @(negedge clk); #1;
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised hh:mm:ss timekeeping core for the digital-clock design, successor to the fixed 24 h clock counter. Features:
- internal prescaler that derives a 1 Hz tick from the system clock;
- field-select up/down adjust with carry/borrow;
- runtime 12/24 h display mode;
- minute alarm with latched ring;
- parametrised seconds progress bar.

Seven-segment decoding stays in the existing display module; this block outputs binary fields only.

Parameters:
TICK_DIV, 50000000, system clocks per one-second tick (>=2)
INIT_H, 0, hour value loaded on reset (0-23)
INIT_M, 0, minute value loaded on reset (0-59)
INIT_S, 0, second value loaded on reset (0-59)
N_LED, 10, progress-bar LED count (1-60)
RING_SECS, 60, ticks an unacknowledged alarm keeps ringing

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = time advances on tick; 0 = frozen (prescaler held at 0)
mode12  in  1  1 = 12 h display on hour_disp/pm; 0 = 24 h
adj_valid  in  1  one-cycle adjust request
adj_field  in  2  0 = sec, 1 = min, 2 = hour, 3 = reserved
adj_dir  in  1  1 = add, 0 = subtract
adj_amt  in  6  adjust magnitude
alarm_en  in  1  alarm armed
alarm_h  in  5  alarm hour (0-23)
alarm_m  in  6  alarm minute (0-59)
alarm_ack  in  1  clears ringing
hour  out  5  hour, 0-23
min  out  6  minute, 0-59
sec  out  6  second, 0-59
hour_disp  out  5  displayed hour (0-23, or 1-12 when mode12)
pm  out  1  1 when hour >= 12
tick  out  1  one-cycle pulse when time advanced by a tick
adj_err  out  1  one-cycle pulse when an adjust was rejected
ringing  out  1  alarm ringing
led  out  N_LED  seconds progress bar

Behaviour:
- Reset (synchronous, dominates all inputs):
  - hour/min/sec = INIT_H/INIT_M/INIT_S; prescaler = 0.
  - tick = adj_err = ringing = 0; tick_pending = 0; ring counter = 0.
- Prescaler:
  - counts 0..TICK_DIV-1 while run = 1; at terminal count it wraps to 0 and raises an internal tick request.
  - With run = 0 it is held at 0 and raises no requests.
- Tick application: sec+1. At 59->0 carry to min; at min 59->0 carry to hour; at hour 23->0 wrap. tick output pulses in the cycle the registers update (1-cycle latency from the terminal count).
- Adjust (adj_valid = 1), applied the cycle after the request, whether run is 0 or 1:
  - Rejected if adj_field = 3, or if adj_amt >= field modulus (60/60/24). On rejection adj_err pulses and time is unchanged.
  - Otherwise amt is added to or subtracted from the selected field, modulo the field range. A carry or borrow propagates into the higher fields only; a borrow from hour wraps 0->23. Example: 00:00:05 minus 10 s gives 23:59:55.
- Simultaneous adjust and tick request:
  - The adjust is applied; tick_pending is set.
  - The deferred tick is applied in the next cycle without an adjust, so no second is ever lost.
  - Any further collision keeps tick_pending set; at most one tick is pending (TICK_DIV >= 2 guarantees it drains).
- Display:
  - hour_disp/pm are combinational from hour.
  - mode12 = 1: hour 0 -> 12, hours 13-23 -> hour-12.
  - pm = (hour >= 12) in both modes.
- Alarm:
  - Ringing sets only on a tick (not an adjust) that lands on min = alarm_m, hour = alarm_h, sec = 0, with alarm_en = 1.
  - Ringing clears on alarm_ack, on alarm_en = 0, or after RING_SECS further ticks.
  - If alarm_ack and a new match occur in the same cycle, the ack wins.
- LED: led[i] = 1 when sec*N_LED > i*60, combinational; all zeros at sec = 0, all ones at sec = 59.
- Width rule: all arithmetic is unsigned and done in 7-bit intermediates. No signed wrap is relied on.

Decomposition:
- Shared package clock_pkg: field encodings FIELD_SEC/FIELD_MIN/FIELD_HOUR, the moduli 60/60/24, and the hms_t struct {hour, min, sec}.
- One sub-module, rtc_prescaler, containing the TICK_DIV counter, the run gating and the tick request output. Everything else stays in rtc_timekeeper.

Test Plan:
- TICK_DIV = 4, INIT = 23:59:58, run = 1 -> tick every 4 clks; sequence 23:59:59, then 00:00:00; pm 1->0.
- Reset asserted mid-count at 12:34:56 -> next cycle shows INIT values and the prescaler restarts; first tick arrives 4 clks after reset release.
- run = 0, time 00:00:05, adjust sec minus 10 -> 23:59:55; adjust hour plus 24 -> adj_err pulse, time unchanged; field 3 -> adj_err pulse.
- Adjust min plus 1 issued in the same cycle as a tick request at 10:20:30 -> 10:21:30 then 10:21:31 one cycle later; tick pulses once.
- mode12 = 1: hour 0 -> hour_disp 12, pm 0; hour 13 -> 1, pm 1; hour 12 -> 12, pm 1.
- Alarm 07:00, en = 1, ticking from 06:59:58 -> ringing at 07:00:00. With no ack, it clears after RING_SECS ticks. Setting the time to 07:00:00 by adjust does not ring. Ack and new match in the same cycle -> ringing = 0.
